// File: rtl/endpoint_switch_ctrl.sv
// endpoint_switch_ctrl: commits a new AXI-MM endpoint select only once the bus has drained
module endpoint_switch_ctrl #(
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter bit RESET_SEL       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel_req,
    output logic                      endpoint_ctrl,
    output logic                      switch_busy,
    output logic                      protocol_err,
    input  logic                      pci_awvalid,
    output logic                      pci_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] pci_awaddr,
    output logic                      sel_awvalid,
    input  logic                      sel_awready,
    output logic [AXI_ADDR_WIDTH-1:0] sel_awaddr,
    input  logic                      pci_arvalid,
    output logic                      pci_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] pci_araddr,
    output logic                      sel_arvalid,
    input  logic                      sel_arready,
    output logic [AXI_ADDR_WIDTH-1:0] sel_araddr,
    input  logic                      mon_wvalid,
    input  logic                      mon_wready,
    input  logic                      mon_wlast,
    input  logic                      mon_bvalid,
    input  logic                      mon_bready,
    input  logic                      mon_rvalid,
    input  logic                      mon_rready,
    input  logic                      mon_rlast
);
    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
    state_t state, state_nxt;
    logic [CNT_WIDTH-1:0] wr_out, rd_out;
    logic w_open, aw_presented, ar_presented;
    logic aw_hs, ar_hs, w_hs, b_hs, r_end;
    logic wr_up, wr_dn, rd_up, rd_dn, err_set;
    logic block_aw, block_ar, idle;
    assign sel_awaddr  = pci_awaddr;
    assign sel_araddr  = pci_araddr;
    // A presented address is never withdrawn, so the gate only closes on fresh addresses
    assign block_aw    = (state != RUN || wr_out == MAX_CNT) && !aw_presented;
    assign block_ar    = (state != RUN || rd_out == MAX_CNT) && !ar_presented;
    assign sel_awvalid = pci_awvalid & ~block_aw;
    assign pci_awready = sel_awready & ~block_aw;
    assign sel_arvalid = pci_arvalid & ~block_ar;
    assign pci_arready = sel_arready & ~block_ar;
    assign aw_hs = sel_awvalid & sel_awready;
    assign ar_hs = sel_arvalid & sel_arready;
    assign w_hs  = mon_wvalid & mon_wready;
    assign b_hs  = mon_bvalid & mon_bready;
    assign r_end = mon_rvalid & mon_rready & mon_rlast;
    // Simultaneous increment and decrement cancel; saturating edges flag a protocol error
    assign wr_up = aw_hs & ~b_hs & (wr_out != MAX_CNT);
    assign wr_dn = b_hs & ~aw_hs & (wr_out != '0);
    assign rd_up = ar_hs & ~r_end & (rd_out != MAX_CNT);
    assign rd_dn = r_end & ~ar_hs & (rd_out != '0);
    assign err_set = (aw_hs & ~b_hs & (wr_out == MAX_CNT)) | (b_hs & ~aw_hs & (wr_out == '0)) |
                     (ar_hs & ~r_end & (rd_out == MAX_CNT)) | (r_end & ~ar_hs & (rd_out == '0));
    assign idle = (wr_out == '0) && (rd_out == '0) && !w_open && !aw_presented && !ar_presented;
    // Outstanding-transaction tracking and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_out       <= '0;
            rd_out       <= '0;
            w_open       <= 1'b0;
            aw_presented <= 1'b0;
            ar_presented <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            wr_out       <= wr_out + CNT_WIDTH'(wr_up) - CNT_WIDTH'(wr_dn);
            rd_out       <= rd_out + CNT_WIDTH'(rd_up) - CNT_WIDTH'(rd_dn);
            w_open       <= w_hs ? ~mon_wlast : w_open;
            aw_presented <= sel_awvalid & ~sel_awready;
            ar_presented <= sel_arvalid & ~sel_arready;
            protocol_err <= protocol_err | err_set;
        end
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end
    // Next state: drain until idle, abandon if the request is withdrawn
    always_comb begin
        state_nxt = state == RUN   ? (sel_req != endpoint_ctrl ? DRAIN : RUN) :
                    state == DRAIN ? (sel_req == endpoint_ctrl ? RUN : idle ? SWITCH : DRAIN) :
                    RUN;
    end
    // Outputs decoded from state
    always_comb begin
        switch_busy = state != RUN;
    end
    // Select flips only in the SWITCH cycle, when the bus is known to be quiescent
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 endpoint_ctrl <= RESET_SEL;
        else if (state == SWITCH) endpoint_ctrl <= ~endpoint_ctrl;
    end
endmodule

// File: tb/tb_endpoint_switch_ctrl.sv
// tb_endpoint_switch_ctrl: directed and random checks of endpoint_switch_ctrl against a behavioural model
module tb_endpoint_switch_ctrl;
    localparam int MAX = 16;
    logic clk = 0, rst = 1, sel_req = 0;
    logic endpoint_ctrl, switch_busy, protocol_err;
    logic pci_awvalid = 0, pci_awready, sel_awvalid, sel_awready = 0;
    logic pci_arvalid = 0, pci_arready, sel_arvalid, sel_arready = 0;
    logic [63:0] pci_awaddr = 0, sel_awaddr, pci_araddr = 0, sel_araddr;
    logic mon_wvalid = 0, mon_wready = 0, mon_wlast = 0;
    logic mon_bvalid = 0, mon_bready = 0;
    logic mon_rvalid = 0, mon_rready = 0, mon_rlast = 0;
    int n_vec = 0, n_err = 0;
    int m_wr, m_rd, m_ph;
    bit m_wo, m_awp, m_arp, m_err, m_ep;

    endpoint_switch_ctrl dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .endpoint_ctrl(endpoint_ctrl),
        .switch_busy(switch_busy), .protocol_err(protocol_err),
        .pci_awvalid(pci_awvalid), .pci_awready(pci_awready), .pci_awaddr(pci_awaddr),
        .sel_awvalid(sel_awvalid), .sel_awready(sel_awready), .sel_awaddr(sel_awaddr),
        .pci_arvalid(pci_arvalid), .pci_arready(pci_arready), .pci_araddr(pci_araddr),
        .sel_arvalid(sel_arvalid), .sel_arready(sel_arready), .sel_araddr(sel_araddr),
        .mon_wvalid(mon_wvalid), .mon_wready(mon_wready), .mon_wlast(mon_wlast),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_ph = 0;
        m_wo = 0; m_awp = 0; m_arp = 0; m_err = 0; m_ep = 0;
    endtask

    task automatic clr();
        pci_awvalid = 0; sel_awready = 0; pci_arvalid = 0; sel_arready = 0;
        mon_wvalid = 0; mon_wready = 0; mon_wlast = 0;
        mon_bvalid = 0; mon_bready = 0;
        mon_rvalid = 0; mon_rready = 0; mon_rlast = 0;
    endtask

    // One clock: check every output against the model, advance the model, wait for the next falling edge
    task automatic cyc();
        bit baw, bar, eaw, ear, aw_hs, ar_hs, b_hs, r_end, idle;
        pci_awaddr = {$urandom, $urandom};
        pci_araddr = {$urandom, $urandom};
        #1;
        baw = (m_ph != 0 || m_wr == MAX) && !m_awp;
        bar = (m_ph != 0 || m_rd == MAX) && !m_arp;
        eaw = pci_awvalid && !baw;
        ear = pci_arvalid && !bar;
        chk("sel_awvalid", sel_awvalid, eaw);
        chk("pci_awready", pci_awready, sel_awready && !baw);
        chk("sel_arvalid", sel_arvalid, ear);
        chk("pci_arready", pci_arready, sel_arready && !bar);
        chk("endpoint_ctrl", endpoint_ctrl, m_ep);
        chk("switch_busy", switch_busy, m_ph != 0);
        chk("protocol_err", protocol_err, m_err);
        n_vec++;
        assert (sel_awaddr === pci_awaddr && sel_araddr === pci_araddr) else begin
            n_err++;
            $error("FAIL addr_pass: got %h/%h expected %h/%h", sel_awaddr, sel_araddr, pci_awaddr, pci_araddr);
        end
        aw_hs = eaw && sel_awready;
        ar_hs = ear && sel_arready;
        b_hs  = mon_bvalid && mon_bready;
        r_end = mon_rvalid && mon_rready && mon_rlast;
        idle  = m_wr == 0 && m_rd == 0 && !m_wo && !m_awp && !m_arp;
        if (aw_hs && !b_hs) begin if (m_wr == MAX) m_err = 1; else m_wr++; end
        else if (b_hs && !aw_hs) begin if (m_wr == 0) m_err = 1; else m_wr--; end
        if (ar_hs && !r_end) begin if (m_rd == MAX) m_err = 1; else m_rd++; end
        else if (r_end && !ar_hs) begin if (m_rd == 0) m_err = 1; else m_rd--; end
        if (mon_wvalid && mon_wready) m_wo = !mon_wlast;
        m_awp = eaw && !sel_awready;
        m_arp = ear && !sel_arready;
        if (m_ph == 0) m_ph = (sel_req != m_ep) ? 1 : 0;
        else if (m_ph == 1) m_ph = (sel_req == m_ep) ? 0 : idle ? 2 : 1;
        else begin m_ep = !m_ep; m_ph = 0; end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Complete every outstanding transaction so the bus is quiescent
    task automatic flush();
        int k;
        for (k = 0; k < 200; k++) begin
            if (m_wr == 0 && m_rd == 0 && !m_wo && !m_awp && !m_arp && m_ph == 0) break;
            clr();
            sel_req = m_ep;
            sel_awready = 1; sel_arready = 1;
            mon_bvalid = m_wr > 0; mon_bready = 1;
            mon_rvalid = m_rd > 0; mon_rready = 1; mon_rlast = 1;
            mon_wvalid = m_wo; mon_wready = 1; mon_wlast = 1;
            cyc();
        end
        n_vec++;
        assert (k < 200) else begin
            n_err++;
            $error("FAIL flush_timeout: got %0d cycles expected < 200", k);
        end
        clr();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ep", endpoint_ctrl, 0);
        chk("rst_busy", switch_busy, 0);
        chk("rst_err", protocol_err, 0);
        rst = 0;
        cyc();
        // idle switch 0 -> 1
        sel_req = 1;
        cyc();
        chk("idle_busy1", switch_busy, 1);
        cyc();
        chk("idle_busy2", switch_busy, 1);
        chk("idle_ep_hold", endpoint_ctrl, 0);
        cyc();
        chk("idle_ep", endpoint_ctrl, 1);
        chk("idle_busy_done", switch_busy, 0);
        pci_awvalid = 1; sel_awready = 1;
        #1 chk("idle_gate_open", pci_awready, 1);
        clr();
        // drain write 1 -> 0
        pci_awvalid = 1; sel_awready = 1; cyc();
        clr(); mon_wvalid = 1; mon_wready = 1; cyc();
        sel_req = 0; cyc();
        clr(); pci_awvalid = 1; sel_awready = 1;
        #1 chk("dw_aw_block", pci_awready, 0);
        cyc();
        clr(); mon_wvalid = 1; mon_wready = 1; mon_wlast = 1; cyc();
        clr(); cyc();
        chk("dw_ep_hold", endpoint_ctrl, 1);
        mon_bvalid = 1; mon_bready = 1; cyc();
        clr(); cyc();
        chk("dw_ep_switching", endpoint_ctrl, 1);
        cyc();
        chk("dw_ep", endpoint_ctrl, 0);
        // drain read 0 -> 1
        pci_arvalid = 1; sel_arready = 1; repeat (3) cyc();
        clr(); sel_req = 1; cyc();
        pci_arvalid = 1; sel_arready = 1;
        #1 chk("dr_ar_block", pci_arready, 0);
        mon_rvalid = 1; mon_rready = 1; cyc();
        mon_rlast = 1; cyc(); cyc();
        chk("dr_ep_hold", endpoint_ctrl, 0);
        cyc();
        clr(); cyc(); cyc();
        chk("dr_ep", endpoint_ctrl, 1);
        // presented AW survives a switch request, 1 -> 0
        pci_awvalid = 1; sel_awready = 0; cyc();
        sel_req = 0; cyc();
        chk("pa_held1", sel_awvalid, 1);
        cyc();
        chk("pa_held2", sel_awvalid, 1);
        sel_awready = 1; cyc();
        sel_awready = 0;
        #1 chk("pa_now_blocked", sel_awvalid, 0);
        cyc(); cyc();
        chk("pa_ep_hold", endpoint_ctrl, 1);
        clr(); mon_bvalid = 1; mon_bready = 1; cyc();
        clr(); cyc(); cyc();
        chk("pa_ep", endpoint_ctrl, 0);
        // outstanding-write limit
        pci_awvalid = 1; sel_awready = 1; repeat (MAX) cyc();
        #1 chk("lim_ready", pci_awready, 0);
        chk("lim_valid", sel_awvalid, 0);
        mon_bvalid = 1; mon_bready = 1; cyc();
        mon_bvalid = 0;
        #1 chk("lim_reopen", pci_awready, 1);
        // withdrawn request
        clr(); sel_req = 1; cyc();
        chk("wd_busy", switch_busy, 1);
        sel_req = 0; cyc();
        chk("wd_run", switch_busy, 0);
        chk("wd_ep", endpoint_ctrl, 0);
        flush();
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) sel_req = ~sel_req;
            pci_awvalid = 1'($urandom_range(1)); sel_awready = 1'($urandom_range(1));
            pci_arvalid = 1'($urandom_range(1)); sel_arready = 1'($urandom_range(1));
            mon_wvalid = 1'($urandom_range(1)); mon_wready = 1'($urandom_range(1)); mon_wlast = 1'($urandom_range(1));
            mon_bvalid = m_wr > 0 && $urandom_range(2) == 0; mon_bready = 1'($urandom_range(1));
            mon_rvalid = m_rd > 0 && $urandom_range(2) == 0; mon_rready = 1'($urandom_range(1)); mon_rlast = 1'($urandom_range(1));
            cyc();
        end
        flush();
        // B with nothing outstanding
        mon_bvalid = 1; mon_bready = 1; cyc();
        chk("err_set", protocol_err, 1);
        clr(); cyc();
        chk("err_sticky", protocol_err, 1);
        // asynchronous reset in the middle of a drain
        sel_req = ~m_ep; repeat (4) cyc();
        sel_req = 1; repeat (4) cyc();
        chk("pre_rst_ep", endpoint_ctrl, 1);
        pci_awvalid = 1; sel_awready = 1; cyc();
        clr(); sel_req = 0; cyc(); cyc();
        chk("pre_rst_busy", switch_busy, 1);
        rst = 1;
        #1;
        chk("arst_ep", endpoint_ctrl, 0);
        chk("arst_busy", switch_busy, 0);
        chk("arst_err", protocol_err, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        pci_awvalid = 1; sel_awready = 1; cyc();
        clr(); cyc(); cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
